rr_arbiter_4ch: RTL and testbench

//  Round-robin arbiter sharing one resource among four requesters.

---
 rtl/rr_arbiter_4ch.sv | 130 +++++++++++++
 tb/tb_rr_arbiter_4ch.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4ch.sv
// Round-robin arbiter for four requesters with a bounded hold time.
// The grant, its encoded index and the valid flag are all registered and
// update together; a contended owner is rotated away after MAX_HOLD cycles,
// while an uncontended owner may keep the grant indefinitely.
// Handshake: req[i] is a level request sampled only at rising clk edges.
// gnt is the matching registered response. It stays asserted while the
// owner keeps req high, subject to the hold limit.
module rr_arbiter_4ch #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [1:0]       gnt_idx,
    output logic             gnt_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [3:0]       gnt_nxt;
    logic [1:0]       idx_nxt;
    logic             valid_nxt;
    logic [CNT_W-1:0] hold_nxt;
    logic [3:0]       others;
    logic [2:0]       idle_pick;
    logic [2:0]       rot_pick;
    logic             do_grant;
    logic             go_idle;
    logic [1:0]       grant_sel;

    // Returns {found, index} for the first set bit of r, scanning upward
    // from start and wrapping. The loop runs backwards so the closest hit
    // is the one left standing.
    function automatic logic [2:0] search(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] cand;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            cand = start + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // Competitors of the current owner, and the two candidate winners.
    assign others    = req & ~gnt;
    assign idle_pick = search(req, ptr);
    assign rot_pick  = search(others, gnt_idx + 2'd1);

    // Next-state and next-output decision; defaults hold everything.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        hold_nxt  = hold_cnt;
        do_grant  = 1'b0;
        go_idle   = 1'b0;
        grant_sel = 2'd0;
        case (state)
            IDLE: begin
                if (idle_pick[2]) begin
                    do_grant  = 1'b1;
                    grant_sel = idle_pick[1:0];
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    // Owner released: hand straight over, or go idle.
                    if (rot_pick[2]) begin
                        do_grant  = 1'b1;
                        grant_sel = rot_pick[1:0];
                    end else begin
                        go_idle = 1'b1;
                    end
                end else if (rot_pick[2] && (hold_cnt == HOLD_LAST)) begin
                    // Hold limit reached under contention: forced rotation.
                    do_grant  = 1'b1;
                    grant_sel = rot_pick[1:0];
                end else if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + CNT_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase
        if (do_grant) begin
            state_nxt = GRANT;
            gnt_nxt   = 4'b0001 << grant_sel;
            idx_nxt   = grant_sel;
            valid_nxt = 1'b1;
            hold_nxt  = '0;
            ptr_nxt   = grant_sel + 2'd1;
        end
        if (go_idle) begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            idx_nxt   = 2'd0;
            valid_nxt = 1'b0;
            hold_nxt  = '0;
        end
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4ch.sv
// Bench for rr_arbiter_4ch: directed scenarios followed by random request
// patterns, with expected outputs produced by an integer reference model.
module tb_rr_arbiter_4ch;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;
    localparam int W        = 7 + CNT_W;

    logic             clk;
    logic             rst_n;
    logic [3:0]       req;
    logic [3:0]       gnt;
    logic [1:0]       gnt_idx;
    logic             gnt_valid;
    logic [CNT_W-1:0] hold_cnt;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state: owner -1 means nobody holds the grant.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ptr   = 0;

    rr_arbiter_4ch #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int find_from(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++) begin
            if (r[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [3:0]       g;
        logic [1:0]       ix;
        logic             v;
        logic [CNT_W-1:0] h;
        g  = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        ix = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        v  = (m_owner >= 0);
        h  = CNT_W'(m_hold);
        return {g, ix, v, h};
    endfunction

    task automatic model_give(input int w);
        m_owner = w;
        m_hold  = 0;
        m_ptr   = (w + 1) % 4;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_ptr   = 0;
    endtask

    task automatic model_step(input logic [3:0] r);
        logic [3:0] rivals;
        if (m_owner < 0) begin
            if (r != 4'b0000) model_give(find_from(r, m_ptr));
        end else begin
            rivals = r;
            rivals[m_owner] = 1'b0;
            if (!r[m_owner]) begin
                if (rivals != 4'b0000) model_give(find_from(rivals, m_owner + 1));
                else begin
                    m_owner = -1;
                    m_hold  = 0;
                end
            end else if (rivals != 4'b0000 && m_hold >= MAX_HOLD - 1) begin
                model_give(find_from(rivals, m_owner + 1));
            end else if (m_hold < MAX_HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    // Model: advances on each clock edge and pushes the expected outputs;
    // an async reset clears it immediately.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step(req);
            if (clk) exp_q.push_back(model_out());
        end
    end

    // Scoreboard monitor: compares DUT outputs on the falling edge.
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        forever begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_v = exp_q.pop_front();
                act_v = {gnt, gnt_idx, gnt_valid, hold_cnt};
                if (act_v !== exp_v) begin
                    errors++;
                    $display("FAIL outputs at %0t: got gnt=%b idx=%0d valid=%b hold=%0d, expected gnt=%b idx=%0d valid=%b hold=%0d",
                             $time, act_v[W-1 -: 4], act_v[W-5 -: 2], act_v[CNT_W], act_v[CNT_W-1:0],
                             exp_v[W-1 -: 4], exp_v[W-5 -: 2], exp_v[CNT_W], exp_v[CNT_W-1:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp_v);
        end
    endtask

    // Holds req at r for n clock edges; returns at falling edge + 1.
    task automatic hold_req(input logic [3:0] r, input int n);
        req = r;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int len;
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        check("reset_gnt", {4'b0, gnt}, 8'h00);
        check("reset_valid", {7'b0, gnt_valid}, 8'h00);

        // Release reset with all requesting: requester 0 first, then rotation.
        rst_n = 1'b1;
        hold_req(4'b1111, 1);
        check("first_gnt", {4'b0, gnt}, 8'h01);
        check("first_hold", {4'b0, hold_cnt}, 8'h00);
        hold_req(4'b1111, 20);
        hold_req(4'b0000, 2);

        // Single requester from idle, then release.
        hold_req(4'b0100, 1);
        check("single_gnt", {4'b0, gnt}, 8'h04);
        check("single_idx", {6'b0, gnt_idx}, 8'h02);
        hold_req(4'b0000, 1);
        check("single_release", {3'b0, gnt_valid, gnt}, 8'h00);

        // Lone holder saturates, then a new contender wins at the next edge.
        hold_req(4'b0010, 20);
        check("lone_gnt", {4'b0, gnt}, 8'h02);
        check("lone_hold_sat", {4'b0, hold_cnt}, 8'(MAX_HOLD - 1));
        hold_req(4'b1010, 1);
        check("lone_rotate", {4'b0, gnt}, 8'h08);

        // Handoff without a gap; the pointer then starts the search at 2.
        hold_req(4'b0000, 2);
        hold_req(4'b0001, 2);
        hold_req(4'b0010, 1);
        check("handoff_gnt", {4'b0, gnt}, 8'h02);
        hold_req(4'b0000, 1);
        check("handoff_idle", {7'b0, gnt_valid}, 8'h00);
        hold_req(4'b1111, 1);
        check("handoff_ptr", {4'b0, gnt}, 8'h04);

        // Async reset in the middle of a grant.
        hold_req(4'b0000, 1);
        hold_req(4'b1000, 2);
        check("pre_reset_gnt", {4'b0, gnt}, 8'h08);
        rst_n = 1'b0;
        #1;
        check("async_reset", {1'b0, gnt_valid, gnt_idx, gnt}, 8'h00);
        check("async_reset_hold", {4'b0, hold_cnt}, 8'h00);
        req = 4'b1001;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        hold_req(4'b1001, 1);
        check("post_reset_gnt", {4'b0, gnt}, 8'h01);

        // Random request patterns with occasional async resets.
        for (int i = 0; i < 120; i++) begin
            len = $urandom_range(1, 10);
            hold_req(4'($urandom_range(0, 15)), len);
            if ($urandom_range(0, 29) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_reset", {4'b0, gnt}, 8'h00);
                @(negedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        hold_req(4'b0000, 3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
